// File: rtl/keypad_scan_if.sv
// Key-pad conditioner bus: raw key lines in, encoded key code plus press strobe out.
// master = the conditioner, slave = the downstream code-entry matcher / key source.
interface keypad_scan_if;
  logic [15:0] KEYS;
  logic [3:0]  BUTTON;
  logic        BPRESS;
  logic        BUSY;

  modport master (
    input  KEYS,
    output BUTTON,
    output BPRESS,
    output BUSY
  );

  modport slave (
    output KEYS,
    input  BUTTON,
    input  BPRESS,
    input  BUSY
  );
endinterface

// File: rtl/keypad_scan.sv
// Synchronises, debounces and encodes the 16-key pad into one BPRESS strobe per press.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scan #(
  parameter int DB_CYCLES     = 1000,
  parameter int CNT_W         = 20,
  parameter int REPEAT_DELAY  = 500000,
  parameter int REPEAT_PERIOD = 100000
) (
  input logic           CLK,
  input logic           RST,
  keypad_scan_if.master kp
);

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    DEBOUNCE_DOWN = 2'd1,
    HELD          = 2'd2,
    DEBOUNCE_UP   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Lowest set bit wins when several keys are down together.
  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      idx = v[i] ? 4'(i) : idx;
    end
    return idx;
  endfunction

  logic [15:0]      s1_q, s1_d;
  logic [15:0]      s2_q, s2_d;
  logic [15:0]      snap_q, snap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t           state_q, state_d;
  logic [3:0]       button_q, button_d;
  logic             bpress_q, bpress_d;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO  = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_FIRE  = HOLD_W'(REPEAT_DELAY - 1);
  // Re-arming here makes the next fire land exactly REPEAT_PERIOD cycles later.
  localparam logic [HOLD_W-1:0] HOLD_REARM = HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD);
  logic [HOLD_W-1:0] hold_q, hold_d;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

  // Next-state, counter and output strobe logic.
  always_comb begin
    s1_d     = kp.KEYS;
    s2_d     = s1_q;
    snap_d   = snap_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    button_d = button_q;
    bpress_d = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    hold_d   = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (s2_q != 16'h0000) begin
          snap_d  = s2_q;
          cnt_d   = CNT_ZERO;
          state_d = DEBOUNCE_DOWN;
        end else begin
          state_d = IDLE;
        end
      end
      DEBOUNCE_DOWN: begin
        if (s2_q == 16'h0000) begin
          cnt_d   = CNT_ZERO;
          state_d = IDLE;
        end else if (s2_q != snap_q) begin
          snap_d = s2_q;
          cnt_d  = CNT_ZERO;
        end else if (cnt_q == DB_LAST) begin
          button_d = lowest_idx(snap_q);
          bpress_d = 1'b1;
          cnt_d    = CNT_ZERO;
          state_d  = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
          hold_d   = HOLD_ZERO;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (s2_q == 16'h0000) begin
          cnt_d   = CNT_ZERO;
          state_d = DEBOUNCE_UP;
        end else begin
          state_d = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
          if (hold_q == HOLD_FIRE) begin
            bpress_d = 1'b1;
            hold_d   = HOLD_REARM;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
`endif
        end
      end
      DEBOUNCE_UP: begin
        if (s2_q != 16'h0000) begin
          cnt_d   = CNT_ZERO;
          state_d = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
          hold_d  = HOLD_ZERO;
`endif
        end else if (cnt_q == DB_LAST) begin
          cnt_d   = CNT_ZERO;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = CNT_ZERO;
        state_d = DEBOUNCE_UP;
      end
    endcase
  end

  // State and output registers; reset lands in DEBOUNCE_UP so a key held through reset never strobes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q     <= 16'h0000;
      s2_q     <= 16'h0000;
      snap_q   <= 16'h0000;
      cnt_q    <= CNT_ZERO;
      state_q  <= DEBOUNCE_UP;
      button_q <= 4'h0;
      bpress_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      hold_q   <= HOLD_ZERO;
`endif
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      snap_q   <= snap_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      button_q <= button_d;
      bpress_q <= bpress_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      hold_q   <= hold_d;
`endif
    end
  end

  assign kp.BUTTON = button_q;
  assign kp.BPRESS = bpress_q;
  assign kp.BUSY   = (state_q != IDLE);

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a run-length reference model checked every cycle.
module tb_keypad_scan;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic CLK = 1'b0;
  logic RST;
  int   total = 0;
  int   bad = 0;
  int   nstrobe = 0;
  bit   chk_en = 1'b0;

  keypad_scan_if kp ();

  keypad_scan #(
    .DB_CYCLES(DB), .CNT_W(8), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .kp(kp)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a press is accepted once the same nonzero pattern has been seen DB+1
  // edges in a row (seen = KEYS two edges late); it is released after DB+1 zero edges.
  logic [15:0] p1, p2, prev_v;
  int          run, zrun, hold;
  bit          armed;
  logic [3:0]  m_button;
  bit          m_bpress, m_busy;

  function automatic logic [3:0] low_code(input logic [15:0] v);
    logic [15:0] iso;
    iso = v & (~v + 16'd1);
    return 4'($clog2(iso));
  endfunction

  initial begin
    forever begin
      logic [15:0] v;
      @(posedge CLK);
      if (RST) begin
        p1 = 16'h0; p2 = 16'h0; prev_v = 16'h0;
        armed = 1'b0; zrun = 1; run = 0; hold = 0;
        m_button = 4'h0; m_bpress = 1'b0;
      end else begin
        v = p2; p2 = p1; p1 = kp.KEYS;
        m_bpress = 1'b0;
        if (armed) begin
          if (v == 16'h0) run = 0;
          else if (run > 0 && v == prev_v) run++;
          else run = 1;
          prev_v = v;
          if (run == DB + 1) begin
            armed = 1'b0; m_button = low_code(v); m_bpress = 1'b1;
            hold = 0; zrun = 0; run = 0;
          end
        end else if (v == 16'h0) begin
          zrun++;
          if (zrun == DB + 1) begin armed = 1'b1; run = 0; end
        end else begin
          if (zrun > 0) hold = 0;
          else hold++;
          zrun = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
          if (hold >= RD && (hold - RD) % RP == 0) m_bpress = 1'b1;
`endif
        end
      end
      m_busy = !(armed && run == 0);
    end
  end

  // Compare process: outputs sampled 1 time unit after each active edge.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (chk_en) begin
        chk("cyc_bpress", 32'(kp.BPRESS), 32'(m_bpress));
        chk("cyc_button", 32'(kp.BUTTON), 32'(m_button));
        chk("cyc_busy", 32'(kp.BUSY), 32'(m_busy));
        if (kp.BPRESS === 1'b1) nstrobe++;
      end
    end
  end

  task automatic negs(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    int s0;
    int got[$];
    int want[$];
    RST = 1'b1;
    kp.KEYS = 16'h0000;
    negs(2);
    chk_en = 1'b1;
    chk("rst_button", 32'(kp.BUTTON), 32'h0);
    chk("rst_bpress", 32'(kp.BPRESS), 32'h0);
    chk("rst_busy", 32'(kp.BUSY), 32'h1);
    RST = 1'b0;
    negs(8);
    chk("idle_busy", 32'(kp.BUSY), 32'h0);

    // clean press of key 5
    s0 = nstrobe;
    kp.KEYS = 16'h0020;
    negs(6);
    chk("press_early", 32'(kp.BPRESS), 32'h0);
    negs(1);
    chk("press_bpress", 32'(kp.BPRESS), 32'h1);
    chk("press_button", 32'(kp.BUTTON), 32'h5);
    negs(1);
    chk("press_fall", 32'(kp.BPRESS), 32'h0);
    negs(1);
    kp.KEYS = 16'h0000;
    negs(6);
    chk("rel_busy_hi", 32'(kp.BUSY), 32'h1);
    negs(1);
    chk("rel_busy_lo", 32'(kp.BUSY), 32'h0);
    chk("press_count", 32'(nstrobe - s0), 32'h1);

    // one-cycle glitch on key 8
    s0 = nstrobe;
    kp.KEYS = 16'h0100;
    negs(1);
    kp.KEYS = 16'h0000;
    negs(10);
    chk("glitch_count", 32'(nstrobe - s0), 32'h0);
    chk("glitch_button", 32'(kp.BUTTON), 32'h5);

    // bouncing key 9, then held
    s0 = nstrobe;
    for (int i = 0; i < 10; i++) begin
      kp.KEYS = (i % 2 == 0) ? 16'h0200 : 16'h0000;
      negs(2);
    end
    chk("bounce_quiet", 32'(nstrobe - s0), 32'h0);
    kp.KEYS = 16'h0200;
    negs(6);
    chk("bounce_early", 32'(kp.BPRESS), 32'h0);
    negs(1);
    chk("bounce_bpress", 32'(kp.BPRESS), 32'h1);
    chk("bounce_button", 32'(kp.BUTTON), 32'h9);
    negs(1);
    kp.KEYS = 16'h0000;
    negs(8);
    chk("bounce_count", 32'(nstrobe - s0), 32'h1);

    // two keys at once, then a change while held
    s0 = nstrobe;
    kp.KEYS = 16'h8004;
    negs(7);
    chk("multi_bpress", 32'(kp.BPRESS), 32'h1);
    chk("multi_button", 32'(kp.BUTTON), 32'h2);
    kp.KEYS = 16'h8000;
    negs(5);
    kp.KEYS = 16'h0000;
    negs(8);
    chk("multi_count", 32'(nstrobe - s0), 32'h1);
    chk("multi_keep", 32'(kp.BUTTON), 32'h2);

    // key held through a reset pulse that lands mid-debounce
    s0 = nstrobe;
    kp.KEYS = 16'h0001;
    negs(3);
    RST = 1'b1;
    negs(1);
    chk("hrst_bpress", 32'(kp.BPRESS), 32'h0);
    chk("hrst_button", 32'(kp.BUTTON), 32'h0);
    chk("hrst_busy", 32'(kp.BUSY), 32'h1);
    RST = 1'b0;
    negs(6);
    chk("hrst_count", 32'(nstrobe - s0), 32'h0);
    chk("hrst_busy_held", 32'(kp.BUSY), 32'h1);
    kp.KEYS = 16'h0000;
    negs(6);
    chk("hrst_busy_rel", 32'(kp.BUSY), 32'h1);
    negs(1);
    chk("hrst_idle", 32'(kp.BUSY), 32'h0);

    // long hold of key 7: strobe offsets from the first sampling edge
    s0 = nstrobe;
`ifdef KEYPAD_AUTOREPEAT_EN
    want = '{6, 16, 21, 26};
`else
    want = '{6};
`endif
    kp.KEYS = 16'h0080;
    for (int k = 0; k < 29; k++) begin
      @(negedge CLK);
      if (kp.BPRESS === 1'b1) begin
        got.push_back(k);
        chk("hold_button", 32'(kp.BUTTON), 32'h7);
      end
    end
    kp.KEYS = 16'h0000;
    negs(10);
    chk("hold_count", 32'(nstrobe - s0), 32'(want.size()));
    chk("hold_seen", 32'(got.size()), 32'(want.size()));
    for (int j = 0; j < want.size(); j++) begin
      chk("hold_offset", (j < got.size()) ? 32'(got[j]) : 32'hffff_ffff, 32'(want[j]));
    end
    chk("hold_idle", 32'(kp.BUSY), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/keypad_scan.md
# keypad_scan

Front-end key conditioner for the digital lock. It takes the raw, asynchronous, bouncing key lines from the 16-key pad, synchronises and debounces them, and encodes the pressed key. It emits exactly one single-cycle BPRESS strobe with a stable 4-bit BUTTON code per physical press. Its outputs drive BUTTON/BPRESS of the code-entry matcher directly downstream.

## Interface
- DB_CYCLES, 1000, consecutive stable cycles required to accept a press or a release; legal range 2..2^CNT_W-1
- CNT_W, 20, width of the debounce counter
- REPEAT_DELAY, 500000, held cycles before the first auto-repeat (used only with KEYPAD_AUTOREPEAT_EN)
- REPEAT_PERIOD, 100000, cycles between later auto-repeats (used only with KEYPAD_AUTOREPEAT_EN)

- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- KEYS  in  16  raw key lines, asynchronous, active-high, bit i = key code i
- BUTTON  out  4  code of the last accepted key; held until the next accepted press
- BPRESS  out  1  one-cycle strobe; BUTTON is valid while it is high
- BUSY  out  1  high whenever state != IDLE

## Operation
- Synchroniser: KEYS passes through two flops, s1 then s2. Both are cleared by RST. All FSM decisions use s2 only.
- State IDLE:
  - s2 == 0: stay.
  - s2 != 0: SNAP <= s2, cnt <= 0, go to DEBOUNCE_DOWN.
- State DEBOUNCE_DOWN:
  - s2 == 0: go to IDLE; the glitch is dropped.
  - s2 != 0 and s2 != SNAP: SNAP <= s2, cnt <= 0, stay.
  - s2 == SNAP and cnt == DB_CYCLES-1: BUTTON <= index of the lowest set bit of SNAP, BPRESS <= 1, go to HELD.
  - Otherwise: cnt <= cnt+1.
- State HELD:
  - Any change among nonzero patterns is ignored. No second press is accepted until every key is released.
  - s2 == 0: cnt <= 0, go to DEBOUNCE_UP.
- State DEBOUNCE_UP:
  - s2 != 0: go to HELD; no new strobe.
  - cnt == DB_CYCLES-1: go to IDLE.
  - Otherwise: cnt <= cnt+1.
- Multiple simultaneous keys: the lowest index wins. Example: KEYS = 16'h0028 gives BUTTON = 3.
- The counter saturates logically. It is compared with == only and is reset on every state entry. The counter never wraps while the design runs in-range.
- BPRESS is never high for two consecutive cycles.

## Timing
- Reset values:
  - state = DEBOUNCE_UP with cnt = 0.
  - BUTTON = 4'h0, BPRESS = 0, BUSY = 1.
  - s1 = s2 = 0, SNAP = 0.
- Because reset enters DEBOUNCE_UP, a key held through reset never produces a strobe. The pad must read all-released for DB_CYCLES cycles before the FSM reaches IDLE.
- Press latency: let edge N be the first edge that samples KEYS at a stable nonzero value. BUTTON updates and BPRESS rises on edge N+DB_CYCLES+2. BPRESS falls on the following edge.
- Release latency: the FSM returns to IDLE DB_CYCLES+2 edges after the first edge that samples KEYS == 0.
- Minimum press-to-press spacing: 2·DB_CYCLES+4 cycles.
- RST asserted mid-debounce or mid-strobe clears BPRESS on that same edge. It discards the pending press and also resets BUTTON.

## Configuration
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined:
  - HELD runs a hold counter, cleared on entry to HELD.
  - After REPEAT_DELAY cycles in HELD, BPRESS pulses once with BUTTON unchanged.
  - After that, BPRESS pulses every REPEAT_PERIOD cycles until the release begins.
  - Leaving HELD stops repeats immediately.
  - The hold counter is sized to hold REPEAT_DELAY.
- Undefined: the hold counter is absent and each physical press gives exactly one strobe.

## Test plan
- Clean press: KEYS = 16'h0020 held for 2·DB_CYCLES cycles with DB_CYCLES = 4 -> BPRESS high for one cycle at edge N+6 with BUTTON = 5. After release, BUSY drops at release edge + 6.
- Bounce: toggle KEYS bit 9 every 2 cycles for 20 cycles, then hold it -> no strobe during bouncing; one strobe with BUTTON = 9, DB_CYCLES+2 edges after bouncing stops.
- Multi-key: KEYS = 16'h8004 held -> one strobe, BUTTON = 2. Changing KEYS to 16'h8000 while in HELD -> no new strobe.
- Held through reset: KEYS = 16'h0001 held, then RST pulsed for 1 cycle -> no BPRESS, BUSY stays 1. Releasing for DB_CYCLES+2 cycles -> BUSY = 0.
- Short glitch: a 1-cycle KEYS = 16'h0100 pulse while IDLE -> no BPRESS and BUTTON unchanged.
- With KEYPAD_AUTOREPEAT_EN, REPEAT_DELAY = 10, REPEAT_PERIOD = 5: hold key 7 -> strobes at the accept edge, then +10, +15, +20 cycles, all with BUTTON = 7. Release -> no further strobes.
